// File: rtl/oam_dma.sv
// oam_dma: copies 160 bus bytes from {src,8'h00} into the 80x16 OAM as byte pairs; ports: clk/rst/ce, cpu_wr/cpu_d/cpu_q register, dma_rd/dma_addr/dma_d_in bus, oam_addr/oam_d_out/oam_we OAM write, dma_active CPU lock
module oam_dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_d_in,
  output logic [6:0]  oam_addr,
  output logic [15:0] oam_d_out,
  output logic        oam_we,
  output logic        dma_active
);
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;
  state_t state, state_n;
  logic [7:0] idx, idx_n, src, src_eff, lo_buf;
  logic act_n, xfer, last;
  assign xfer = state == XFER;
  assign last = idx == 8'd159;
  assign src_eff = src >= 8'hE0 ? (src & 8'hDF) : src;
  assign dma_rd = ce & xfer;
  assign dma_addr = {src_eff, idx};
  assign oam_we = ce & xfer & idx[0];
  assign oam_addr = idx[7:1];
  assign oam_d_out = {lo_buf, dma_d_in};
  // A register write restarts the copy but holds the lock as-is, so a restart mid-copy never unlocks
  always_comb begin
    state_n = cpu_wr ? START : state == START ? XFER : xfer && last ? IDLE : state;
    idx_n = cpu_wr || !xfer || last ? 8'd0 : idx + 8'd1;
    act_n = cpu_wr ? dma_active : state == START ? 1'b1 : xfer && last ? 1'b0 : dma_active;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= 8'd0;
      src <= 8'hFF;
      cpu_q <= 8'hFF;
      lo_buf <= 8'h00;
      dma_active <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      idx <= idx_n;
      dma_active <= act_n;
      if (cpu_wr) begin
        src <= cpu_d;
        cpu_q <= cpu_d;
      end
      if (xfer && !idx[0]) lo_buf <= dma_d_in;
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed checks of oam_dma latency, remap, restart, ce gating and reset
module tb_oam_dma;
  logic clk = 1'b0;
  logic rst, ce, cpu_wr, mix;
  logic [7:0] cpu_d, cpu_q, dma_d_in;
  logic dma_rd, oam_we, dma_active;
  logic [15:0] dma_addr, oam_d_out;
  logic [6:0] oam_addr, last_waddr;
  logic [15:0] addr_first, addr_last;
  logic [15:0] oam_m [80];
  int n_chk = 0, n_err = 0;
  int we_cnt, first_we, last_we, act_first, act_last, act_cnt, rd_cnt, order_bad, gate_bad;
  oam_dma dut (.clk(clk), .rst(rst), .ce(ce), .cpu_wr(cpu_wr), .cpu_d(cpu_d), .cpu_q(cpu_q),
    .dma_rd(dma_rd), .dma_addr(dma_addr), .dma_d_in(dma_d_in), .oam_addr(oam_addr),
    .oam_d_out(oam_d_out), .oam_we(oam_we), .dma_active(dma_active));
  always #5 clk = ~clk;
  function automatic logic [7:0] bus(input logic [15:0] a, input logic m);
    return m ? a[7:0] ^ a[15:8] : a[7:0];
  endfunction
  assign dma_d_in = bus(dma_addr, mix);
  always @(posedge clk) if (oam_we) oam_m[oam_addr] <= oam_d_out;
  function automatic int oam_bad(input logic [7:0] hi);
    int n = 0;
    for (int k = 0; k < 80; k++) begin
      logic [7:0] e = 8'(2 * k);
      if (oam_m[k] !== {bus({hi, e}, mix), bus({hi, e + 8'd1}, mix)}) n++;
    end
    return n;
  endfunction
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task clr;
    we_cnt = 0; rd_cnt = 0; act_cnt = 0; order_bad = 0; gate_bad = 0;
    first_we = -1; last_we = -1; act_first = -1; act_last = -1;
    addr_first = 16'h0; addr_last = 16'h0; last_waddr = 7'h7F;
  endtask
  task tick(input logic c, input logic w, input logic [7:0] d, input int t);
    @(negedge clk);
    ce = c; cpu_wr = w; cpu_d = d;
    #1;
    if (c) begin
      if (oam_we) begin
        if (oam_addr != 7'(we_cnt)) order_bad++;
        if (first_we < 0) first_we = t;
        last_we = t; last_waddr = oam_addr; we_cnt++;
      end
      if (dma_active) begin
        if (act_first < 0) act_first = t;
        act_last = t; act_cnt++;
      end
      if (dma_rd) begin
        if (rd_cnt == 0) addr_first = dma_addr;
        addr_last = dma_addr; rd_cnt++;
      end
    end else if (oam_we || dma_rd) gate_bad++;
  endtask
  initial begin
    rst = 1'b1; ce = 1'b0; cpu_wr = 1'b0; cpu_d = 8'h00; mix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_act", dma_active, 0);
    chk("rst_cpu_q", cpu_q, 8'hFF);
    chk("rst_strobes", {dma_rd, oam_we}, 0);
    @(negedge clk); rst = 1'b0;
    clr;
    for (int t = 0; t < 10; t++) tick(1, 0, 8'h00, t);
    chk("idle_we", we_cnt, 0);
    chk("idle_rd", rd_cnt, 0);
    chk("idle_act", act_cnt, 0);
    chk("idle_cpu_q", cpu_q, 8'hFF);
    clr;
    for (int t = 0; t < 166; t++) tick(1, t == 0, 8'hC1, t);
    chk("c1_we_cnt", we_cnt, 80);
    chk("c1_first_we", first_we, 3);
    chk("c1_last_we", last_we, 161);
    chk("c1_act_first", act_first, 2);
    chk("c1_act_last", act_last, 161);
    chk("c1_rd_cnt", rd_cnt, 160);
    chk("c1_addr_first", addr_first, 16'hC100);
    chk("c1_addr_last", addr_last, 16'hC19F);
    chk("c1_order", order_bad, 0);
    chk("c1_word0", oam_m[0], 16'h0001);
    chk("c1_word79", oam_m[79], 16'h9E9F);
    chk("c1_oam", oam_bad(8'hC1), 0);
    chk("c1_end_act", dma_active, 0);
    mix = 1'b1;
    clr;
    for (int t = 0; t < 166; t++) tick(1, t == 0, 8'hE3, t);
    chk("e3_addr_first", addr_first, 16'hC300);
    chk("e3_addr_last", addr_last, 16'hC39F);
    chk("e3_cpu_q", cpu_q, 8'hE3);
    chk("e3_oam", oam_bad(8'hC3), 0);
    clr;
    for (int t = 0; t < 215; t++) tick(1, t == 0 || t == 50, t < 50 ? 8'hC0 : 8'hD0, t);
    chk("rs_act_first", act_first, 2);
    chk("rs_act_last", act_last, 211);
    chk("rs_act_cont", act_cnt, 210);
    chk("rs_we_cnt", we_cnt, 104);
    chk("rs_last_we", last_we, 211);
    chk("rs_word0", oam_m[0], 16'hD0D1);
    chk("rs_oam", oam_bad(8'hD0), 0);
    chk("rs_cpu_q", cpu_q, 8'hD0);
    clr;
    for (int c = 0; c < 4 * 166; c++) tick(c % 4 == 0, c == 0, 8'h80, c / 4);
    chk("ce_we_cnt", we_cnt, 80);
    chk("ce_first_we", first_we, 3);
    chk("ce_last_we", last_we, 161);
    chk("ce_order", order_bad, 0);
    chk("ce_gate", gate_bad, 0);
    chk("ce_rd_cnt", rd_cnt, 160);
    chk("ce_oam", oam_bad(8'h80), 0);
    clr;
    for (int t = 0; t < 331; t++) begin
      tick(1, t == 0 || t == 161, t < 161 ? 8'h10 : 8'h20, t);
      if (t == 161) begin
        chk("w159_we", oam_we, 1);
        chk("w159_word", oam_d_out, 16'h8E8F);
      end
    end
    chk("w159_we_cnt", we_cnt, 160);
    chk("w159_act_last", act_last, 322);
    chk("w159_act_cont", act_cnt, 321);
    chk("w159_oam", oam_bad(8'h20), 0);
    mix = 1'b0;
    clr;
    for (int t = 0; t < 100; t++) tick(1, t == 0, 8'hC1, t);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("ar_act", dma_active, 0);
    chk("ar_strobes", {dma_rd, oam_we}, 0);
    chk("ar_cpu_q", cpu_q, 8'hFF);
    for (int t = 0; t < 3; t++) tick(1, 0, 8'h00, 200 + t);
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 20; t++) tick(1, 0, 8'h00, 300 + t);
    chk("ar_we_cnt", we_cnt, 49);
    chk("ar_last_word", last_waddr, 48);
    chk("ar_last_we", last_we, 99);
    chk("ar_rd_cnt", rd_cnt, 98);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
